// File: rtl/iob_cache_wtbuf_merge.sv
// Write-through buffer with merging of writes to the youngest entry.
// Front-end writes queue in order and drain to the back-end over valid/ready.
// A hazard lookup reports whether a word address still has a write pending.
module iob_cache_wtbuf_merge #(
    parameter int unsigned ADDR_W   = 30,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH_W  = 2,
    parameter int unsigned MERGE_EN = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                w_valid_i,
    input  logic [ADDR_W-1:0]   w_addr_i,
    input  logic [DATA_W-1:0]   w_data_i,
    input  logic [DATA_W/8-1:0] w_strb_i,
    output logic                w_ready_o,
    output logic                be_valid_o,
    output logic [ADDR_W-1:0]   be_addr_o,
    output logic [DATA_W-1:0]   be_data_o,
    output logic [DATA_W/8-1:0] be_strb_o,
    input  logic                be_ready_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    output logic                rd_pending_o,
    output logic [DEPTH_W:0]    level_o,
    output logic                empty_o,
    output logic                full_o,
    output logic                merged_o
);

    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned DEPTH  = 2 ** DEPTH_W;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [NBYTES-1:0] strb_mem [DEPTH];

    logic [DEPTH_W-1:0] rd_ptr;
    logic [DEPTH_W-1:0] wr_ptr;
    logic [DEPTH_W-1:0] youngest;
    logic [DEPTH_W-1:0] offset;
    logic [DEPTH_W:0]   level;
    logic               merged;

    logic               strb_nz;
    logic               merge_hit;
    logic               merge_do;
    logic               push;
    logic               pop;
    logic [DATA_W-1:0]  merge_data;
    logic [NBYTES-1:0]  merge_strb;

    assign youngest   = wr_ptr - DEPTH_W'(1);
    assign strb_nz    = |w_strb_i;
    assign empty_o    = (level == '0);
    assign full_o     = (level == (DEPTH_W+1)'(DEPTH));
    assign level_o    = level;
    assign merged_o   = merged;
    assign be_valid_o = !empty_o;
    assign be_addr_o  = addr_mem[rd_ptr];
    assign be_data_o  = data_mem[rd_ptr];
    assign be_strb_o  = strb_mem[rd_ptr];

    // Merge only into the youngest entry, and only when it is not the head.
    assign merge_hit = (MERGE_EN != 0) && strb_nz &&
                       (level >= (DEPTH_W+1)'(2)) &&
                       (w_addr_i == addr_mem[youngest]);

    // Zero-strobe writes are always accepted and then discarded.
    assign w_ready_o = !full_o || merge_hit || !strb_nz;
    assign merge_do  = w_valid_i && merge_hit;
    assign push      = w_valid_i && strb_nz && !merge_hit && !full_o;
    assign pop       = be_valid_o && be_ready_i;

    // Byte-strobe combine of the incoming write onto the youngest entry.
    always_comb begin
        merge_data = data_mem[youngest];
        merge_strb = strb_mem[youngest] | w_strb_i;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            if (w_strb_i[b]) begin
                merge_data[8*b +: 8] = w_data_i[8*b +: 8];
            end
        end
    end

    // Hazard lookup over every occupied slot, head included.
    always_comb begin
        rd_pending_o = 1'b0;
        offset       = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset = DEPTH_W'(i) - rd_ptr;
            if (({1'b0, offset} < level) && (addr_mem[i] == rd_addr_i)) begin
                rd_pending_o = 1'b1;
            end
        end
    end

    // Entry storage: new entries at wr_ptr, merges into the youngest slot.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[wr_ptr] <= w_addr_i;
            data_mem[wr_ptr] <= w_data_i;
            strb_mem[wr_ptr] <= w_strb_i;
        end else if (merge_do) begin
            data_mem[youngest] <= merge_data;
            strb_mem[youngest] <= merge_strb;
        end
    end

    // Pointers, occupancy counter and merge pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            merged <= 1'b0;
        end else begin
            merged <= merge_do;
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (DEPTH_W+1)'(1);
                2'b01:   level <= level - (DEPTH_W+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_cache_wtbuf_merge.sv
// Bench for the write-through merge buffer: one merging and one plain-FIFO
// instance share the same stimulus and are compared against a queue model.
module tb_iob_cache_wtbuf_merge;

    localparam int AW    = 30;
    localparam int DW    = 32;
    localparam int DWID  = 2;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** DWID;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [NB-1:0] s;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          w_valid;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic [NB-1:0] w_strb;
    logic          be_ready;
    logic [AW-1:0] rd_addr;

    logic          w_ready    [2];
    logic          be_valid   [2];
    logic [AW-1:0] be_addr    [2];
    logic [DW-1:0] be_data    [2];
    logic [NB-1:0] be_strb    [2];
    logic          rd_pending [2];
    logic [DWID:0] level      [2];
    logic          empty      [2];
    logic          full       [2];
    logic          merged     [2];

    int checks   = 0;
    int failures = 0;

    ent_t mq [2][$];
    logic m_merged [2];

    iob_cache_wtbuf_merge #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_W(DWID), .MERGE_EN(1)) dut (
        .clk_i(clk), .rst_i(rst), .w_valid_i(w_valid), .w_addr_i(w_addr),
        .w_data_i(w_data), .w_strb_i(w_strb), .w_ready_o(w_ready[0]),
        .be_valid_o(be_valid[0]), .be_addr_o(be_addr[0]), .be_data_o(be_data[0]),
        .be_strb_o(be_strb[0]), .be_ready_i(be_ready), .rd_addr_i(rd_addr),
        .rd_pending_o(rd_pending[0]), .level_o(level[0]), .empty_o(empty[0]),
        .full_o(full[0]), .merged_o(merged[0])
    );

    iob_cache_wtbuf_merge #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_W(DWID), .MERGE_EN(0)) dut_nm (
        .clk_i(clk), .rst_i(rst), .w_valid_i(w_valid), .w_addr_i(w_addr),
        .w_data_i(w_data), .w_strb_i(w_strb), .w_ready_o(w_ready[1]),
        .be_valid_o(be_valid[1]), .be_addr_o(be_addr[1]), .be_data_o(be_data[1]),
        .be_strb_o(be_strb[1]), .be_ready_i(be_ready), .rd_addr_i(rd_addr),
        .rd_pending_o(rd_pending[1]), .level_o(level[1]), .empty_o(empty[1]),
        .full_o(full[1]), .merged_o(merged[1])
    );

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Instance 0 merges, instance 1 is a plain FIFO.
    function automatic bit m_hit(input int k);
        int n = mq[k].size();
        return (k == 0) && (n >= 2) && (w_strb != '0) && (w_addr == mq[k][n-1].a);
    endfunction

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            int n = mq[k].size();
            bit pend = 0;
            foreach (mq[k][i]) if (mq[k][i].a == rd_addr) pend = 1;
            chk("level", k, 64'(level[k]), 64'(n));
            chk("empty", k, 64'(empty[k]), 64'(n == 0));
            chk("full", k, 64'(full[k]), 64'(n == DEPTH));
            chk("be_valid", k, 64'(be_valid[k]), 64'(n > 0));
            chk("w_ready", k, 64'(w_ready[k]), 64'((n < DEPTH) || m_hit(k) || (w_strb == '0)));
            chk("rd_pending", k, 64'(rd_pending[k]), 64'(pend));
            chk("merged", k, 64'(merged[k]), 64'(m_merged[k]));
            if (n > 0) begin
                chk("be_addr", k, 64'(be_addr[k]), 64'(mq[k][0].a));
                chk("be_data", k, 64'(be_data[k]), 64'(mq[k][0].d));
                chk("be_strb", k, 64'(be_strb[k]), 64'(mq[k][0].s));
            end
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mq[k].delete();
                m_merged[k] = 1'b0;
            end else begin
                int n   = mq[k].size();
                bit hit = m_hit(k);
                bit acc = w_valid && ((n < DEPTH) || hit || (w_strb == '0));
                m_merged[k] = w_valid && hit;
                if (acc && hit) begin
                    ent_t e = mq[k][n-1];
                    for (int b = 0; b < NB; b++)
                        if (w_strb[b]) e.d[8*b +: 8] = w_data[8*b +: 8];
                    e.s = e.s | w_strb;
                    mq[k][n-1] = e;
                end
                if (n > 0 && be_ready) void'(mq[k].pop_front());
                if (acc && !hit && (w_strb != '0)) begin
                    ent_t e;
                    e.a = w_addr; e.d = w_data; e.s = w_strb;
                    mq[k].push_back(e);
                end
            end
        end
    endtask

    task automatic look();
        #3;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step();
        look();
        tick();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] s);
        w_valid = 1'b1; w_addr = a; w_data = d; w_strb = s;
    endtask

    task automatic drain();
        w_valid = 1'b0; be_ready = 1'b1;
        repeat (5) step();
        be_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; w_valid = 1'b0; w_addr = '0; w_data = '0; w_strb = '0;
        be_ready = 1'b0; rd_addr = '0;
        m_merged[0] = 1'b0; m_merged[1] = 1'b0;
        tick();
        step();
        chk("rst_level", 0, 64'(level[0]), 64'd0);
        rst = 1'b0;

        // Single write then pop
        wr(30'h10, 32'hAABBCCDD, 4'hF); step();
        w_valid = 1'b0; look();
        chk("s1_addr", 0, 64'(be_addr[0]), 64'h10);
        chk("s1_level", 0, 64'(level[0]), 64'd1);
        tick();
        be_ready = 1'b1; step();
        be_ready = 1'b0; look();
        chk("s1_empty", 0, 64'(empty[0]), 64'd1);
        tick();

        // Merge into youngest; plain FIFO keeps three entries
        wr(30'h10, 32'h11111111, 4'hF); step();
        wr(30'h20, 32'h000000AA, 4'h1); step();
        wr(30'h20, 32'h0000BB00, 4'h2); step();
        w_valid = 1'b0; look();
        chk("s2_level", 0, 64'(level[0]), 64'd2);
        chk("s2_merged", 0, 64'(merged[0]), 64'd1);
        chk("s2_level_nm", 1, 64'(level[1]), 64'd3);
        tick();
        be_ready = 1'b1; step();
        be_ready = 1'b0; look();
        chk("s2_addr", 0, 64'(be_addr[0]), 64'h20);
        chk("s2_data", 0, 64'(be_data[0]), 64'h0000BBAA);
        chk("s2_strb", 0, 64'(be_strb[0]), 64'h3);
        tick();
        drain();

        // Head entry is never a merge target
        wr(30'h30, 32'h12345678, 4'hF); step();
        wr(30'h30, 32'h9ABCDEF0, 4'hF); step();
        w_valid = 1'b0; look();
        chk("s3_level", 0, 64'(level[0]), 64'd2);
        chk("s3_merged", 0, 64'(merged[0]), 64'd0);
        tick();
        drain();

        // Full buffer: stall new address, allow merge
        for (int i = 0; i < 4; i++) begin
            wr(30'(32'h40 + i), $urandom, 4'hF); step();
        end
        wr(30'h50, 32'hDEADBEEF, 4'hF); look();
        chk("s4_full", 0, 64'(full[0]), 64'd1);
        chk("s4_stall", 0, 64'(w_ready[0]), 64'd0);
        tick();
        wr(30'h43, 32'h99000000, 4'h8); look();
        chk("s4_merge_rdy", 0, 64'(w_ready[0]), 64'd1);
        tick();
        w_valid = 1'b0; look();
        chk("s4_level", 0, 64'(level[0]), 64'd4);
        chk("s4_merged", 0, 64'(merged[0]), 64'd1);
        tick();
        drain();

        // Simultaneous push and pop at level 2
        wr(30'h70, 32'h70707070, 4'hF); step();
        wr(30'h71, 32'h71717171, 4'hF); step();
        wr(30'h60, 32'h60606060, 4'hF); be_ready = 1'b1; step();
        w_valid = 1'b0; be_ready = 1'b0; rd_addr = 30'h60; look();
        chk("s5_level", 0, 64'(level[0]), 64'd2);
        chk("s5_head", 0, 64'(be_addr[0]), 64'h71);
        chk("s5_pend60", 0, 64'(rd_pending[0]), 64'd1);
        rd_addr = 30'h70; look();
        chk("s5_pend70", 0, 64'(rd_pending[0]), 64'd0);
        be_ready = 1'b1; tick();
        be_ready = 1'b0; look();
        chk("s5_head2", 0, 64'(be_addr[0]), 64'h60);
        tick();
        drain();

        // Reset discards queued entries; zero-strobe write is dropped
        for (int i = 0; i < 3; i++) begin
            wr(30'(32'h80 + i), $urandom, 4'hF); step();
        end
        w_valid = 1'b0; rst = 1'b1; step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd_addr = 30'(32'h80 + i); look();
            chk("s6_pend", 0, 64'(rd_pending[0]), 64'd0);
        end
        chk("s6_valid", 0, 64'(be_valid[0]), 64'd0);
        wr(30'h90, 32'h12121212, 4'h0); look();
        chk("s6_zs_rdy", 0, 64'(w_ready[0]), 64'd1);
        tick();
        w_valid = 1'b0; look();
        chk("s6_zs_level", 0, 64'(level[0]), 64'd0);
        chk("s6_zs_merged", 0, 64'(merged[0]), 64'd0);
        tick();

        // Randomised traffic over a small address set to provoke merges
        for (int c = 0; c < 400; c++) begin
            w_valid  = ($urandom_range(0, 3) != 0);
            w_addr   = 30'(32'h100 + $urandom_range(0, 2));
            w_data   = $urandom;
            w_strb   = NB'($urandom_range(0, 15));
            be_ready = ($urandom_range(0, 2) == 0);
            rd_addr  = 30'(32'h100 + $urandom_range(0, 3));
            rst      = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0; w_valid = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iob_cache_wtbuf_merge.md
Name: iob_cache_wtbuf_merge

Overview:
Parametrised write-through buffer for the cache front-end. It replaces the plain synchronous FIFO used for write-through traffic. Front-end writes are queued and drained in order to the back-end over a valid/ready port. A write to the same word as the youngest queued entry is merged into that entry (byte-strobe combine). A read-hazard lookup reports whether a word address still has a write pending.

Parameters:
ADDR_W, 30, word address width (byte offset already stripped)
DATA_W, 32, data width; NBYTES = DATA_W/8
DEPTH_W, 2, log2 of entry count (2**DEPTH_W entries, DEPTH_W >= 1)
MERGE_EN, 1, 1 enables merging; 0 gives plain FIFO behaviour

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
w_valid_i  in  1  front-end write request
w_addr_i  in  ADDR_W  write word address
w_data_i  in  DATA_W  write data
w_strb_i  in  NBYTES  byte strobes
w_ready_o  out  1  write accepted when w_valid_i & w_ready_o
be_valid_o  out  1  head entry valid
be_addr_o  out  ADDR_W  head address
be_data_o  out  DATA_W  head data
be_strb_o  out  NBYTES  head strobes
be_ready_i  in  1  back-end pops head when be_valid_o & be_ready_i
rd_addr_i  in  ADDR_W  hazard lookup address
rd_pending_o  out  1  some valid entry matches rd_addr_i (combinational)
level_o  out  DEPTH_W+1  occupied entries
empty_o  out  1  level_o == 0
full_o  out  1  level_o == 2**DEPTH_W
merged_o  out  1  registered one-cycle pulse per merge

Behaviour:
- Reset (rst_i=1 at a clock edge): read/write pointers 0, level_o 0, empty_o 1, full_o 0, be_valid_o 0, merged_o 0. Entry storage is not reset. Reset mid-operation discards all queued entries; outputs show reset values the cycle after.
- Circular storage of entries {addr, data, strb}. Pointers wrap modulo 2**DEPTH_W. level_o is an explicit counter.
- be_valid_o = !empty_o. be_addr_o, be_data_o and be_strb_o come from the head entry registers, with no combinational path from w_*.
- Push latency: a write accepted in cycle N into an empty buffer appears on be_valid_o in cycle N+1.
- Merge hit (comb) requires all of: MERGE_EN=1, level_o >= 2, w_addr_i == address of the youngest entry (wr_ptr-1). The head entry is never a merge target because it is already presented to the back-end.
- Merge action: for each byte b with w_strb_i[b]=1, replace data byte b and set strb[b]. level_o is unchanged. merged_o=1 the next cycle.
- w_ready_o = !full_o | merge_hit. It does not depend on be_ready_i (no ready-to-ready path). A full buffer stalls a non-merging write even when a pop occurs in the same cycle.
- Zero-strobe write (w_strb_i==0): w_ready_o=1. The write is accepted and dropped, with no entry, no merge and no merged_o.
- Level update per cycle: non-merge push only → +1. Pop only → -1. Both → unchanged, with order preserved. A merge counts as no push.
- Merge and pop in the same cycle are legal because the target is never the head. Both take effect.
- rd_pending_o compares rd_addr_i against every occupied entry, including the head and an entry being popped this cycle. It does not see a write accepted in the current cycle.
- Illegal case: pop when empty cannot occur because be_valid_o=0 when empty. be_ready_i is ignored when empty.

Test Plan:
- Reset; write addr 0x10, data 0xAABBCCDD, strb 0xF with be_ready_i=0 → next cycle be_valid_o=1, be_addr_o=0x10, level_o=1. Then be_ready_i=1 for one cycle → level_o=0, empty_o=1.
- be_ready_i=0; writes (0x10,0x11111111,F), (0x20,0x000000AA,0x1), (0x20,0x0000BB00,0x2) → level_o=2, merged_o pulses once. After popping 0x10, the head shows addr 0x20, data 0x0000BBAA, strb 0x3.
- Single entry 0x30 at head; write 0x30 again → no merge, level_o=2, merged_o=0. MERGE_EN=0 run of the previous scenario → level_o=3.
- Fill with 0x40..0x43 (DEPTH_W=2) → full_o=1. Write to 0x50 → w_ready_o=0. Write to 0x43 with strb 0x8 → w_ready_o=1, merge, level_o stays 4.
- Level 2, simultaneous accepted write 0x60 and pop → level_o=2. Drain order is the old second entry, then 0x60. rd_pending_o=1 for 0x60 and 0 for the popped address.
- Three entries queued, assert rst_i for one cycle → level_o=0, be_valid_o=0, rd_pending_o=0 for all previously queued addresses. Zero-strobe write afterwards → accepted, level_o stays 0.
